result_collector: RTL and testbench
===================================

# result_collector

Downstream consumer of the data-processing stage: samples its `processed_data` and `error_flag` outputs and buffers them in a first-word-fall-through FIFO. The FIFO drains over a valid/ready handshake. The block also keeps saturating counters of overflow errors, even-value errors and words dropped on a full buffer, so the host side can read results at its own pace and monitor error rates.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16 — width of each statistics counter.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — upstream word present this cycle.
- `processed_data` in 32 — upstream data word.
- `error_flag` in 2 — bit0 = overflow error, bit1 = even-value error.
- `out_valid` out 1 — head entry available.
- `out_ready` in 1 — consumer accepts the head entry.
- `out_data` out 32 — head entry data.
- `out_err` out 2 — head entry error flags.
- `fifo_level` out $clog2(DEPTH)+1 — current occupancy, 0..DEPTH.
- `clear_counts` in 1 — synchronous clear of all counters.
- `ovf_count` out CNT_W — saturating count of overflow flags.
- `even_count` out CNT_W — saturating count of even-value flags.
- `drop_count` out CNT_W — saturating count of words lost to a full FIFO.

## Operation
- Entry = {error_flag, processed_data}, 34 bits.
- Push condition: `in_valid` && `fifo_level` != DEPTH, with DEPTH judged on the registered level.
  - A push attempted while full is dropped, even if a pop occurs in the same cycle.
- Drop on full: `drop_count` += 1.
- Pop condition: `out_valid` && `out_ready`.
  - `out_ready` while empty is ignored.
- Simultaneous push and pop (not full): level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- `out_valid` = (`fifo_level` != 0).
- `out_data`/`out_err` show the head entry whenever `out_valid` = 1. They read 0 when empty.
- Counting is independent of FIFO acceptance. On every cycle with `in_valid` = 1:
  - `ovf_count` += `error_flag[0]`.
  - `even_count` += `error_flag[1]`.
- All counters saturate at 2^CNT_W−1 and never wrap.
- `clear_counts` = 1 zeroes all three counters at the next edge and overrides any same-cycle increment. FIFO contents are unaffected.
- Reset, including mid-operation, behaves as follows:
  - Pointers, `fifo_level` and all counters go to 0.
  - `out_valid`, `out_data` and `out_err` go to 0.
  - FIFO contents are discarded.

## Timing
- Push-to-visible latency: a word pushed at edge N raises `out_valid` and appears on `out_data` after edge N, i.e. one cycle after it was sampled.
- Pop: the head advances at the edge where `out_valid` && `out_ready`. The next entry, if any, is visible in the following cycle with no bubble.
- `fifo_level` and the counters are registered and update one edge after the causing event.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `out_valid`.

## Configuration
- `RESULT_FILTER_EN` defined:
  - Words with `error_flag` != 0 are not enqueued.
  - They are still counted in `ovf_count`/`even_count`.
  - They never count toward `drop_count`.
  - The FIFO holds only clean results.
- Not defined: every `in_valid` word is a push candidate, subject only to the full condition.

## Structure
- Shared package `result_pkg` holds:
  - `RESULT_DATA_W` = 32 and `RESULT_ERR_W` = 2.
  - Error bit indices `ERR_OVF` = 0 and `ERR_EVEN` = 1.
  - `result_entry_t` packed struct {err, data}.
- One sub-module, `result_fifo`: parameterized FWFT storage with pointers and level, push/pop inputs and full/empty outputs.
- Counters and filter logic live in the top level.

## Test plan
- Reset mid-stream with 5 entries queued → next cycle:
  - `fifo_level` = 0, `out_valid` = 0, all counters 0.
  - After release, pushing 0x10 yields `out_data` = 0x10 one cycle later.
- Ordering and latency: push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready` = 0, then hold `out_ready` = 1 → `out_data` sequence 1, 2, 3 with no gaps; `fifo_level` goes 1, 2, 3 then 2, 1, 0.
- Full and drop (DEPTH = 8): 10 consecutive pushes with `out_ready` = 0 → `fifo_level` = 8, `drop_count` = 2, contents = first 8 words.
- Full with simultaneous pop: FIFO at 8, `in_valid` and `out_ready` both 1 for one cycle → `fifo_level` = 7, `drop_count` += 1.
- Counters, with CNT_W forced to 4:
  - 20 words with `error_flag` = 2'b11 → `ovf_count` = `even_count` = 15 (saturated).
  - Then `clear_counts` pulsed with `in_valid` = 1 and `error_flag` = 2'b01 → both counters 0.
- Filter build (`RESULT_FILTER_EN`): push data 0xA with flag 2'b00, then 0xB with flag 2'b10 → only 0xA enqueued, `even_count` = 1, `drop_count` = 0.

Source files
------------

// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
// Shared definitions for the result collector: word widths, error-flag bit
// positions and the packed FIFO entry layout {err, data}.
// -----------------------------------------------------------------------------
package result_pkg;

    localparam int RESULT_DATA_W = 32;
    localparam int RESULT_ERR_W  = 2;

    // Bit positions inside error_flag
    localparam int ERR_OVF  = 0;
    localparam int ERR_EVEN = 1;

    // One buffered result; err occupies the upper bits so the packed value
    // equals {error_flag, processed_data}.
    typedef struct packed {
        logic [RESULT_ERR_W-1:0]  err;
        logic [RESULT_DATA_W-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/result_collector_if.sv
// -----------------------------------------------------------------------------
// result_collector_if
// Handshake bundle of the result collector.
//   Input side : in_valid, processed_data, error_flag (from the processing stage)
//   Output side: out_valid, out_data, out_err (to the host), out_ready (from host)
// Modports:
//   slave  - the collector (consumes the input side, drives the output side)
//   master - the environment around it
// -----------------------------------------------------------------------------
interface result_collector_if;
    import result_pkg::*;

    logic                     in_valid;
    logic [RESULT_DATA_W-1:0] processed_data;
    logic [RESULT_ERR_W-1:0]  error_flag;

    logic                     out_valid;
    logic                     out_ready;
    logic [RESULT_DATA_W-1:0] out_data;
    logic [RESULT_ERR_W-1:0]  out_err;

    modport slave (
        input  in_valid,
        input  processed_data,
        input  error_flag,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_err
    );

    modport master (
        output in_valid,
        output processed_data,
        output error_flag,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_err
    );

endinterface

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// First-word-fall-through FIFO of result_entry_t.
// Parameters:
//   DEPTH - number of entries, power of two, >= 2
// Ports:
//   clk, reset    - clock (rising edge), asynchronous active-high reset
//   push          - write push_entry this cycle (ignored when full)
//   push_entry    - entry to store
//   pop           - retire the head entry this cycle (ignored when empty)
//   head_entry    - current head entry, all zeros when empty
//   full, empty   - occupancy flags derived from the registered level
//   level         - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module result_fifo
    import result_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  result_entry_t          push_entry,
    input  logic                   pop,
    output result_entry_t          head_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    result_entry_t     mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // A push while full is lost even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is read straight from storage so a word is visible the cycle after
    // it was written; zeroed while empty so stale contents never leak out.
    assign head_entry = empty ? '0 : mem[rd_ptr];

    // Storage carries data only; validity is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
// Buffers {error_flag, processed_data} words from the processing stage in an
// FWFT FIFO drained over a valid/ready handshake, and keeps saturating counts
// of overflow flags, even-value flags and words dropped on a full buffer.
// Parameters:
//   DEPTH - FIFO entries (power of two, >= 2)
//   CNT_W - width of each statistics counter
// Ports:
//   clk, reset   - clock (rising edge), asynchronous active-high reset
//   bus          - result_collector_if.slave handshake bundle
//   fifo_level   - current FIFO occupancy, 0..DEPTH
//   clear_counts - synchronous clear of all three counters (wins over counting)
//   ovf_count    - saturating count of error_flag[ERR_OVF] on valid cycles
//   even_count   - saturating count of error_flag[ERR_EVEN] on valid cycles
//   drop_count   - saturating count of push candidates lost to a full FIFO
// Build option:
//   RESULT_FILTER_EN - when defined, words with a non-zero error_flag are not
//                      enqueued (still counted as errors, never as drops).
// -----------------------------------------------------------------------------
module result_collector
    import result_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    result_collector_if.slave      bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    input  logic                   clear_counts,
    output logic [CNT_W-1:0]       ovf_count,
    output logic [CNT_W-1:0]       even_count,
    output logic [CNT_W-1:0]       drop_count
);

    result_entry_t in_entry;
    result_entry_t head_entry;
    logic          candidate;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             inc);
        if (inc && (value != '1)) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    assign in_entry.err  = bus.error_flag;
    assign in_entry.data = bus.processed_data;

`ifdef RESULT_FILTER_EN
    // Only clean results are eligible for the buffer.
    assign candidate = bus.in_valid && (bus.error_flag == '0);
`else
    assign candidate = bus.in_valid;
`endif

    assign push = candidate && !fifo_full;
    assign drop = candidate && fifo_full;
    assign pop  = bus.out_ready && !fifo_empty;

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // out_valid depends only on registered state, never on in_valid/out_ready.
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head_entry.data;
    assign bus.out_err   = head_entry.err;

    // Error counting looks at every valid word, whether or not it was buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count  <= '0;
            even_count <= '0;
            drop_count <= '0;
        end else if (clear_counts) begin
            ovf_count  <= '0;
            even_count <= '0;
            drop_count <= '0;
        end else begin
            ovf_count  <= sat_inc(ovf_count,  bus.in_valid && bus.error_flag[ERR_OVF]);
            even_count <= sat_inc(even_count, bus.in_valid && bus.error_flag[ERR_EVEN]);
            drop_count <= sat_inc(drop_count, drop);
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// -----------------------------------------------------------------------------
// tb_result_collector
// Directed and randomized stimulus for result_collector (DEPTH = 8, CNT_W = 4)
// checked against a queue-based reference model of the collector behaviour.
// -----------------------------------------------------------------------------
module tb_result_collector;
    import result_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear_counts;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] ovf_count;
    logic [CNT_W-1:0] even_count;
    logic [CNT_W-1:0] drop_count;

    result_collector_if bus();

    result_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .fifo_level   (fifo_level),
        .clear_counts (clear_counts),
        .ovf_count    (ovf_count),
        .even_count   (even_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of buffered {err, data} words plus plain counters.
    logic [33:0] q[$];
    int          m_ovf  = 0;
    int          m_even = 0;
    int          m_drop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int value, input bit inc);
        return (inc && value < CNT_MAX) ? value + 1 : value;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_even = 0;
        m_drop = 0;
    endtask

    task automatic check_all();
        logic [33:0] head;
        head = (q.size() != 0) ? q[0] : 34'd0;
        chk("level",      64'(fifo_level),    64'(q.size()));
        chk("out_valid",  64'(bus.out_valid), 64'(q.size() != 0));
        chk("out_data",   64'(bus.out_data),  64'(head[31:0]));
        chk("out_err",    64'(bus.out_err),   64'(head[33:32]));
        chk("ovf_count",  64'(ovf_count),     64'(m_ovf));
        chk("even_count", 64'(even_count),    64'(m_even));
        chk("drop_count", 64'(drop_count),    64'(m_drop));
    endtask

    // One clock cycle: drive inputs, predict, advance past the edge, compare.
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] e,
                        input logic rdy, input logic clr);
        bit cand, full, do_push, do_pop;
        bus.in_valid       = v;
        bus.processed_data = d;
        bus.error_flag     = e;
        bus.out_ready      = rdy;
        clear_counts       = clr;
        cand = v;
`ifdef RESULT_FILTER_EN
        if (e != 2'b00) cand = 1'b0;
`endif
        full    = (q.size() == DEPTH);
        do_push = cand && !full;
        do_pop  = rdy && (q.size() != 0);
        @(posedge clk);
        if (clr) begin
            m_ovf  = 0;
            m_even = 0;
            m_drop = 0;
        end else begin
            m_ovf  = sat(m_ovf,  v && e[0]);
            m_even = sat(m_even, v && e[1]);
            m_drop = sat(m_drop, cand && full);
        end
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({e, d});
        #1;
        check_all();
        bus.in_valid = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 2'b00, rdy, 1'b0);
    endtask

    initial begin
        reset              = 1'b1;
        clear_counts       = 1'b0;
        bus.in_valid       = 1'b0;
        bus.processed_data = '0;
        bus.error_flag     = '0;
        bus.out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Ordering and latency
        step(1'b1, 32'h1, 2'b00, 1'b0, 1'b0);
        chk("ord_first", 64'(bus.out_data), 64'h1);
        step(1'b1, 32'h2, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'h3, 2'b00, 1'b0, 1'b0);
        chk("ord_lvl3", 64'(fifo_level), 64'd3);
        idle(1'b1);
        chk("ord_pop1", 64'(bus.out_data), 64'h2);
        idle(1'b1);
        chk("ord_pop2", 64'(bus.out_data), 64'h3);
        idle(1'b1);
        chk("ord_empty", 64'(bus.out_valid), 64'd0);

        // Full and drop, then full with a simultaneous pop
        step(1'b0, 32'd0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), 2'b00, 1'b0, 1'b0);
        chk("full_lvl", 64'(fifo_level), 64'd8);
        chk("full_drop", 64'(drop_count), 64'd2);
        chk("full_head", 64'(bus.out_data), 64'h100);
        step(1'b1, 32'hDEAD, 2'b00, 1'b1, 1'b0);
        chk("fullpop_lvl", 64'(fifo_level), 64'd7);
        chk("fullpop_drop", 64'(drop_count), 64'd3);
        chk("fullpop_head", 64'(bus.out_data), 64'h101);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Counter saturation and clear priority
        step(1'b0, 32'd0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), 2'b11, 1'b1, 1'b0);
        chk("sat_ovf", 64'(ovf_count), 64'(CNT_MAX));
        chk("sat_even", 64'(even_count), 64'(CNT_MAX));
        step(1'b1, 32'h300, 2'b01, 1'b1, 1'b1);
        chk("clr_ovf", 64'(ovf_count), 64'd0);
        chk("clr_even", 64'(even_count), 64'd0);
        for (int i = 0; i < 2; i++) idle(1'b1);

`ifdef RESULT_FILTER_EN
        // Only clean words are buffered
        step(1'b0, 32'd0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'hA, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hB, 2'b10, 1'b0, 1'b0);
        chk("filt_lvl", 64'(fifo_level), 64'd1);
        chk("filt_data", 64'(bus.out_data), 64'hA);
        chk("filt_even", 64'(even_count), 64'd1);
        chk("filt_drop", 64'(drop_count), 64'd0);
        idle(1'b1);
`endif

        // Asynchronous reset with 5 entries queued
        for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i), 2'b00, 1'b0, 1'b0);
        chk("pre_rst_lvl", 64'(fifo_level), 64'd5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        step(1'b1, 32'h10, 2'b00, 1'b0, 1'b0);
        chk("rst_push", 64'(bus.out_data), 64'h10);
        idle(1'b1);

        // Randomized traffic with varying consumer pressure
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                logic v, rdy, clr;
                v   = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 3) < phase);
                clr = ($urandom_range(0, 40) == 0);
                step(v, $urandom, 2'($urandom_range(0, 3)), rdy, clr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
